uart_rxd: RTL and testbench

- Serial receiver paired with the UART transmitter in this core.
- Consumes the serial line, recovers 8N1 frames (MSB first, matching the transmitter's bit order) and presents each byte on a parallel port with a valid/ack handshake.
- Reports framing and overrun errors.
- Sits between the pad/loopback line and the byte consumer (FIFO or CPU register).

---
 rtl/uart_rxd_if.sv | 11 +
 rtl/uart_rxd.sv | 84 ++++++++
 tb/tb_uart_rxd.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_rxd_if.sv
// uart_rxd_if: parallel byte handshake and status between the UART receiver and its consumer
interface uart_rxd_if;
    logic       ack;
    logic [7:0] q;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    modport master (input ack, output q, valid, frame_err, overrun, busy);
    modport slave  (output ack, input q, valid, frame_err, overrun, busy);
endinterface

// File: rtl/uart_rxd.sv
// uart_rxd: 8N1 serial receiver, MSB first, with valid/ack handshake and framing/overrun pulses
module uart_rxd #(
    parameter int unsigned clock_frequency = 100_000_000,
    parameter int unsigned baud_rate       = 115_200,
    parameter int unsigned div             = clock_frequency / baud_rate,
    parameter int unsigned div_half        = div / 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rxd,
    uart_rxd_if.master  bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    state_t      state, state_nxt;
    logic        rxd_m, rxd_s;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic [7:0]  q_r;
    logic        valid_r, frame_err_r, overrun_r;
    logic        tick, load, bad;
    assign tick = cnt == 16'(div);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {rxd_s, rxd_m} <= 2'b11;
            state          <= IDLE;
            cnt            <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
        end else begin
            {rxd_s, rxd_m} <= {rxd_m, rxd};
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            bit_cnt        <= bit_cnt_nxt;
            shreg          <= shreg_nxt;
        end
    end
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        load        = 1'b0;
        bad         = 1'b0;
        case (state)
            IDLE:  if (!rxd_s) state_nxt = START;
            START: if (cnt == 16'(div_half)) begin
                       state_nxt   = rxd_s ? IDLE : DATA;
                       bit_cnt_nxt = '0;
                   end
            DATA:  if (tick) begin
                       shreg_nxt   = {shreg[6:0], rxd_s};
                       bit_cnt_nxt = bit_cnt + 3'd1;
                       if (bit_cnt == 3'd7) state_nxt = STOP;
                   end
            STOP:  if (tick) begin
                       load      = rxd_s;
                       bad       = !rxd_s;
                       state_nxt = rxd_s ? IDLE : BREAK;
                   end
            BREAK: if (rxd_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // counter restarts on every state entry and on each bit tick, and idles at zero
        cnt_nxt = (state == IDLE || state_nxt != state || tick) ? '0 : cnt + 16'd1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r         <= '0;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            q_r         <= load ? shreg : q_r;
            valid_r     <= load | (valid_r & ~bus.ack);
            frame_err_r <= bad;
            overrun_r   <= load & valid_r & ~bus.ack;
        end
    end
    assign bus.q         = q_r;
    assign bus.valid     = valid_r;
    assign bus.frame_err = frame_err_r;
    assign bus.overrun   = overrun_r;
    assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_uart_rxd.sv
// tb_uart_rxd: directed table plus randomized frames against a cycle-level handshake model
module tb_uart_rxd;
    localparam int unsigned div = 10;
    localparam int unsigned div_half = 5;
    localparam longint lat = 2 + div_half + 9 * (div + 1) + 1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd = 1'b1;
    uart_rxd_if bus();
    uart_rxd #(.div(div), .div_half(div_half)) dut (.clk(clk), .rst_n(rst_n), .rxd(rxd), .bus(bus));
    always #5 clk = ~clk;
    int n_vec = 0;
    int n_bad = 0;
    longint cyc = 0;
    longint pend_cyc = -1;
    logic [7:0] pend_d = '0;
    bit pend_good = 1'b0;
    bit mvalid, ef, eo, hit, a;
    logic [7:0] mq;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int busy_rise = 0;
    longint valid_rise = 0;
    longint busy_fall = 0;
    bit pv = 1'b0;
    bit pb = 1'b0;
    typedef struct {
        logic [7:0] d;
        bit         stop;
        int         ack_mode;
        bit         ack_after;
        logic [7:0] eq;
        bit         ev;
        int         efe;
        int         eov;
    } vec_t;
    vec_t tbl[10];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask
    // model: a good frame loads exactly lat edges after the first edge that sees the start bit
    initial begin
        mvalid = 1'b0;
        mq = '0;
        ef = 1'b0;
        eo = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            a = bus.ack;
            if (!rst_n) begin
                mvalid = 1'b0;
                mq = '0;
                ef = 1'b0;
                eo = 1'b0;
            end else begin
                hit = cyc == pend_cyc;
                ef = hit && !pend_good;
                eo = hit && pend_good && mvalid && !a;
                if (hit && pend_good) begin
                    mvalid = 1'b1;
                    mq = pend_d;
                end else if (a) mvalid = 1'b0;
            end
            #1;
            chk("valid", bus.valid, mvalid);
            chk("q", bus.q, mq);
            chk("frame_err", bus.frame_err, ef);
            chk("overrun", bus.overrun, eo);
            if (bus.frame_err) fe_cnt++;
            if (bus.overrun) ov_cnt++;
            if (bus.busy && !pb) busy_rise++;
            if (!bus.busy && pb) busy_fall = cyc;
            if (bus.valid && !pv) valid_rise = cyc;
            pb = bus.busy;
            pv = bus.valid;
        end
    end
    task automatic send_frame(input logic [7:0] d, input bit stop, input int ack_mode, input int extra_low, input int gap);
        logic [9:0] fr;
        longint f;
        fr = {1'b0, d, stop};
        f = cyc + 1;
        pend_d = d;
        pend_good = stop;
        pend_cyc = f + lat;
        for (int i = 9; i >= 0; i--) begin
            rxd = fr[i];
            for (int j = 0; j < 11; j++) begin
                bus.ack = ack_mode == 1 ? (cyc + 1 == f + lat) : ack_mode == 2 ? ($urandom_range(0, 5) == 0) : 1'b0;
                @(negedge clk);
            end
        end
        bus.ack = 1'b0;
        if (!stop) repeat (extra_low) @(negedge clk);
        rxd = 1'b1;
        repeat (gap) @(negedge clk);
    endtask
    initial begin
        int b0, fe0, ov0;
        longint f;
        logic [9:0] fr;
        bus.ack = 1'b0;
        tbl[0] = '{8'hA5, 1'b1, 0, 1'b1, 8'hA5, 1'b1, 0, 0};
        tbl[1] = '{8'h00, 1'b1, 0, 1'b1, 8'h00, 1'b1, 0, 0};
        tbl[2] = '{8'hFF, 1'b1, 0, 1'b1, 8'hFF, 1'b1, 0, 0};
        tbl[3] = '{8'h3C, 1'b1, 0, 1'b1, 8'h3C, 1'b1, 0, 0};
        tbl[4] = '{8'h81, 1'b0, 0, 1'b0, 8'h3C, 1'b0, 1, 0};
        tbl[5] = '{8'h42, 1'b1, 0, 1'b1, 8'h42, 1'b1, 0, 0};
        tbl[6] = '{8'h11, 1'b1, 0, 1'b0, 8'h11, 1'b1, 0, 0};
        tbl[7] = '{8'h22, 1'b1, 0, 1'b0, 8'h22, 1'b1, 0, 1};
        tbl[8] = '{8'h33, 1'b1, 1, 1'b0, 8'h33, 1'b1, 0, 0};
        tbl[9] = '{8'h44, 1'b0, 1, 1'b0, 8'h33, 1'b0, 1, 0};
        repeat (3) @(negedge clk);
        chk("reset_busy", bus.busy, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        b0 = busy_rise;
        fe0 = fe_cnt;
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_busy_pulse", busy_rise - b0, 1);
        chk("glitch_busy_idle", bus.busy, 1'b0);
        chk("glitch_no_fe", fe_cnt - fe0, 0);
        for (int i = 0; i < 10; i++) begin
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            f = cyc + 1;
            send_frame(tbl[i].d, tbl[i].stop, tbl[i].ack_mode, 50, 5);
            chk("tbl_q", bus.q, tbl[i].eq);
            chk("tbl_valid", bus.valid, tbl[i].ev);
            chk("tbl_fe_pulses", fe_cnt - fe0, tbl[i].efe);
            chk("tbl_ov_pulses", ov_cnt - ov0, tbl[i].eov);
            if (i == 0) begin
                chk("valid_rise_latency", 32'(valid_rise - f), 32'(lat));
                chk("busy_fall_latency", 32'(busy_fall - f), 32'(lat));
            end
            if (tbl[i].ack_after) begin
                bus.ack = 1'b1;
                @(negedge clk);
                bus.ack = 1'b0;
                @(negedge clk);
            end
        end
        for (int i = 0; i < 40; i++)
            send_frame(8'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 2), $urandom_range(0, 30), $urandom_range(3, 15));
        fr = {1'b0, 8'h96, 1'b1};
        rxd = 1'b0;
        for (int i = 9; i > 4; i--) begin
            rxd = fr[i];
            repeat (11) @(negedge clk);
        end
        rxd = fr[4];
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_mid_busy", bus.busy, 1'b0);
        chk("rst_mid_valid", bus.valid, 1'b0);
        chk("rst_mid_q", bus.q, 8'h00);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        chk("rst_no_spurious_valid", bus.valid, 1'b0);
        send_frame(8'h5A, 1'b1, 0, 0, 5);
        chk("post_rst_q", bus.q, 8'h5A);
        chk("post_rst_valid", bus.valid, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
